simo_fifo: RTL
==============

SIMO_FIFO -- requirements
Module: simo_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 32, number of byte entries.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, bits per entry.
REQ-003 SHALL have parameter DATA_LENGTH, default 9, number of output lanes; DATA_LENGTH >= 8 is required.
REQ-004 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_nrst, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port i_clear, input, 1, synchronous flush of pointers and outputs.
REQ-007 SHALL have port i_write_en, input, 1, write one entry this cycle.
REQ-008 SHALL have port i_data, input, DATA_WIDTH, write data.
REQ-009 SHALL have port i_read_en, input, 1, request one parallel read.
REQ-010 SHALL have port i_r_pointer_reset, input, 1, rewind read pointer for replay.
REQ-011 SHALL have port i_p_mode, input, 2, lanes per read L: 00->1, 01->4, 10->8, 11->DATA_LENGTH.
REQ-012 SHALL have port o_data, output, DATA_LENGTH x DATA_WIDTH, lane-packed read data, lane 0 = oldest.
REQ-013 SHALL have port o_valid, output, DATA_LENGTH, per-lane valid of last read.
REQ-014 SHALL have port o_read_valid, output, 1, o_data/o_valid updated by an accepted read.
REQ-015 SHALL have ports o_empty and o_full, output, 1 each, status flags.

Function
REQ-016 SHALL store entries linearly; wptr and rptr SHALL be $clog2(DEPTH)+1 bits, with no wrap-around.
REQ-017 SHALL assert o_full combinationally when wptr == DEPTH and o_empty combinationally when rptr >= wptr.
REQ-018 SHALL accept a write iff i_write_en && !o_full: mem[wptr] <= i_data, wptr += 1; a write while full SHALL be dropped.
REQ-019 SHALL accept a read iff i_read_en && !o_empty: n = min(L, wptr - rptr), rptr += n.
REQ-020 SHALL, on an accepted read, register lanes k < n as o_data[k] = mem[rptr+k], o_valid[k] = 1; lanes k >= n SHALL be driven to data 0, valid 0.
REQ-021 SHALL assert o_read_valid for exactly one cycle, the cycle after read acceptance (1-cycle latency); o_data/o_valid SHALL hold until the next accepted read, clear or reset.
REQ-022 SHALL ignore a read while empty: o_read_valid = 0 and outputs held.
REQ-023 SHALL, on simultaneous accepted write and read, perform both; the read SHALL see only entries present before the edge.
REQ-024 SHALL read without destroying entries; i_r_pointer_reset SHALL set rptr = 0 and retain contents and wptr.
REQ-025 SHALL give priority i_clear > i_r_pointer_reset > read; write SHALL still occur with i_r_pointer_reset but SHALL be suppressed by i_clear.
REQ-026 SHALL sample i_p_mode at read acceptance; a mode change between reads is legal.
REQ-027 SHALL, on i_clear, set wptr = rptr = 0, o_valid = 0, o_read_valid = 0 and o_data = 0 on the next edge.

Reset
REQ-028 SHALL, while i_nrst = 0, immediately force wptr, rptr, o_data, o_valid and o_read_valid to 0 (o_empty = 1, o_full = 0); memory contents SHALL NOT be reset.
REQ-029 SHALL abort any in-flight read when reset is asserted mid-operation; the first accepted read after deassertion SHALL behave as if from a fresh clear.

Configuration
REQ-030 SHALL, with SIMO_FIFO_OVERFLOW_FLAG_EN defined, add output port o_overflow (1 bit), sticky-set on write attempted while full and cleared by reset or i_clear.
REQ-031 SHALL, without SIMO_FIFO_OVERFLOW_FLAG_EN, omit the o_overflow port and all related logic; the remaining behaviour SHALL be identical.

Verification
REQ-032 SHALL cover: p_mode=00, write 8'h11, 8'h22, then two reads -> o_data[0] = 11 then 22, o_valid = 9'h001 each, then o_empty = 1.
REQ-033 SHALL cover: p_mode=01, write 01..05, read twice -> lanes 01,02,03,04 valid 9'h00F; then lane0 = 05, valid 9'h001, other lanes 0.
REQ-034 SHALL cover: p_mode=11, write 01..09, one read -> all 9 lanes 01..09, o_valid = 9'h1FF; then i_r_pointer_reset and read -> identical output.
REQ-035 SHALL cover: 33 writes at DEPTH=32 -> o_full after the 32nd; the 33rd is dropped and o_overflow = 1 when the macro is defined; readback ends at the 32nd value.
REQ-036 SHALL cover: read on an empty FIFO -> o_read_valid stays 0; simultaneous write of AA and read on an empty FIFO -> no read, next read returns AA.
REQ-037 SHALL cover: i_nrst pulsed low between two clock edges mid-stream -> outputs 0 immediately, o_empty = 1.

Source files
------------

// File: rtl/simo_fifo.sv
// Single-input, multiple-output FIFO: one byte written per cycle, up to
// DATA_LENGTH entries read in parallel per cycle. Storage is linear (no
// wrap-around) and reads are non-destructive, so the read pointer can be
// rewound to replay the stored contents.
// Optional feature: define SIMO_FIFO_OVERFLOW_FLAG_EN to add a sticky
// o_overflow output flagging writes attempted while full.
module simo_fifo #(
   parameter int unsigned DEPTH       = 32,
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned DATA_LENGTH = 9   // must be >= 8 so mode 2'b10 fits
) (
   input  logic                              i_clk,
   input  logic                              i_nrst,
   input  logic                              i_clear,
   input  logic                              i_write_en,
   input  logic [DATA_WIDTH-1:0]             i_data,
   input  logic                              i_read_en,
   input  logic                              i_r_pointer_reset,
   input  logic [1:0]                        i_p_mode,
   output logic [DATA_LENGTH*DATA_WIDTH-1:0] o_data,
   output logic [DATA_LENGTH-1:0]            o_valid,
   output logic                              o_read_valid,
   output logic                              o_empty,
`ifdef SIMO_FIFO_OVERFLOW_FLAG_EN
   output logic                              o_overflow,
`endif
   output logic                              o_full
);

   localparam int unsigned PW = $clog2(DEPTH) + 1;
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_WIDTH-1:0]             mem_q [DEPTH];
   logic [PW-1:0]                     wptr_q, wptr_d;
   logic [PW-1:0]                     rptr_q, rptr_d;
   logic [DATA_LENGTH*DATA_WIDTH-1:0] data_q, data_d;
   logic [DATA_LENGTH-1:0]            valid_q, valid_d;
   logic                              read_valid_q, read_valid_d;

   logic        full, empty;
   logic        wr_acc, rd_acc;
   logic [31:0] lanes, avail, n_rd;

   assign full  = (wptr_q == PW'(DEPTH));
   assign empty = (rptr_q >= wptr_q);

   // Clear suppresses the write; pointer rewind and clear both block the read.
   assign wr_acc = i_write_en && !full && !i_clear;
   assign rd_acc = i_read_en && !empty && !i_clear && !i_r_pointer_reset;

   // Lanes per read and the number actually delivered (bounded by stored data).
   always_comb begin
      lanes = 32'd1;
      case (i_p_mode)
         2'b00:   lanes = 32'd1;
         2'b01:   lanes = 32'd4;
         2'b10:   lanes = 32'd8;
         default: lanes = 32'(DATA_LENGTH);
      endcase
      avail = 32'(wptr_q) - 32'(rptr_q);
      n_rd  = (avail < lanes) ? avail : lanes;
   end

   // Next-state for pointers and registered read outputs.
   always_comb begin
      wptr_d       = wptr_q;
      rptr_d       = rptr_q;
      data_d       = data_q;
      valid_d      = valid_q;
      read_valid_d = 1'b0;
      if (i_clear) begin
         wptr_d  = '0;
         rptr_d  = '0;
         data_d  = '0;
         valid_d = '0;
      end else begin
         if (wr_acc) begin
            wptr_d = wptr_q + PW'(1);
         end
         if (i_r_pointer_reset) begin
            rptr_d = '0;
         end else if (rd_acc) begin
            rptr_d       = rptr_q + PW'(n_rd);
            read_valid_d = 1'b1;
            for (int unsigned k = 0; k < DATA_LENGTH; k++) begin
               if (k < n_rd) begin
                  // Only indexed when in range: rptr + k < wptr <= DEPTH.
                  data_d[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[AW'(32'(rptr_q) + k)];
                  valid_d[k]                         = 1'b1;
               end else begin
                  data_d[k*DATA_WIDTH +: DATA_WIDTH] = '0;
                  valid_d[k]                         = 1'b0;
               end
            end
         end
      end
   end

   // Storage write; contents deliberately survive reset and clear.
   always_ff @(posedge i_clk) begin
      if (wr_acc) begin
         mem_q[AW'(wptr_q)] <= i_data;
      end
   end

   // Pointer and output registers with asynchronous reset.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         wptr_q       <= '0;
         rptr_q       <= '0;
         data_q       <= '0;
         valid_q      <= '0;
         read_valid_q <= 1'b0;
      end else begin
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
         read_valid_q <= read_valid_d;
      end
   end

   assign o_data       = data_q;
   assign o_valid      = valid_q;
   assign o_read_valid = read_valid_q;
   assign o_empty      = empty;
   assign o_full       = full;

`ifdef SIMO_FIFO_OVERFLOW_FLAG_EN
   logic overflow_q, overflow_d;

   // Sticky flag: set by a write attempt while full, cleared only by clear/reset.
   always_comb begin
      overflow_d = overflow_q;
      if (i_clear) begin
         overflow_d = 1'b0;
      end else if (i_write_en && full) begin
         overflow_d = 1'b1;
      end
   end

   // Overflow flag register.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end

   assign o_overflow = overflow_q;
`else
   // Overflow tracking not built in this configuration.
`endif

endmodule
